// File: rtl/switch_output_arbiter_pkg.sv
// Shared definitions for the switch output arbiter: flit control-field codes,
// control/destination bit positions and the arbiter FSM state encoding.
package switch_output_arbiter_pkg;

    localparam int unsigned CTRL_W      = 3;
    localparam int unsigned HEADER_BIT  = 0;
    localparam int unsigned NOTTAIL_BIT = 1;
    localparam int unsigned DEST_LSB    = 3;

    localparam logic [CTRL_W-1:0] CTRL_HEADER  = 3'b011;
    localparam logic [CTRL_W-1:0] CTRL_PAYLOAD = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_TAIL    = 3'b000;
    localparam logic [CTRL_W-1:0] CTRL_SINGLE  = 3'b001;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    // True for any of the four legal control codes.
    function automatic logic ctrl_is_legal(input logic [CTRL_W-1:0] ctrl);
        return (ctrl == CTRL_HEADER) || (ctrl == CTRL_PAYLOAD) ||
               (ctrl == CTRL_TAIL)   || (ctrl == CTRL_SINGLE);
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr+1 with wrap-around; returns one-hot grant, binary index and a valid flag.
module rr_priority_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned LOGN = 2
) (
    input  logic [N-1:0]    req,
    input  logic [LOGN-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [LOGN-1:0] idx,
    output logic            valid
);

    logic [LOGN-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = LOGN'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/switch_output_arbiter.sv
// Per-output wormhole round-robin arbiter with stall/go flow control.
// Optional activity counters are built when SWITCH_ARB_STATS_EN is defined.
module switch_output_arbiter
    import switch_output_arbiter_pkg::*;
#(
    parameter int unsigned FLITWIDTH        = 32,
    parameter int unsigned NUMBERINPUTS     = 4,
    parameter int unsigned LOGNUMBERINPUTS  = 2,
    parameter int unsigned LOGNUMBEROUTPUTS = 2,
    parameter int unsigned PORTID           = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUMBERINPUTS*FLITWIDTH-1:0] FLIT_in,
    input  logic [NUMBERINPUTS-1:0]           VALID_in,
    output logic [NUMBERINPUTS-1:0]           STALL_out,
    output logic [FLITWIDTH-1:0]              FLIT_out,
    output logic                              VALID_out,
    input  logic                              STALL_in,
    output logic [NUMBERINPUTS-1:0]           GRANT_out
`ifdef SWITCH_ARB_STATS_EN
    ,
    output logic [15:0]                       PKT_COUNT_out,
    output logic [15:0]                       STALL_COUNT_out
`endif
);

    logic [FLITWIDTH-1:0]       flits [NUMBERINPUTS];
    logic [NUMBERINPUTS-1:0]    req;

    arb_state_t                 state_q, state_d;
    logic [LOGNUMBERINPUTS-1:0] owner_q, owner_d;
    logic [LOGNUMBERINPUTS-1:0] ptr_q, ptr_d;
    logic [NUMBERINPUTS-1:0]    grant_q, grant_d;

    logic [NUMBERINPUTS-1:0]    pick_grant;
    logic [LOGNUMBERINPUTS-1:0] pick_idx;
    logic                       pick_valid;
    logic                       xfer;

    // Only headers addressed to this port compete for the output.
    for (genvar i = 0; i < NUMBERINPUTS; i++) begin : g_req
        assign flits[i] = FLIT_in[i*FLITWIDTH +: FLITWIDTH];
        assign req[i]   = VALID_in[i] & flits[i][HEADER_BIT] &
                          (flits[i][DEST_LSB +: LOGNUMBEROUTPUTS] == LOGNUMBEROUTPUTS'(PORTID));
    end

    rr_priority_picker #(
        .N    (NUMBERINPUTS),
        .LOGN (LOGNUMBERINPUTS)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= LOGNUMBERINPUTS'(NUMBERINPUTS - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    // Lock is released the cycle after the owner's tail is accepted.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        FLIT_out  = '0;
        VALID_out = 1'b0;
        STALL_out = '1;
        xfer      = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d = ARB_LOCKED;
                    owner_d = pick_idx;
                    grant_d = pick_grant;
                end
            end
            ARB_LOCKED: begin
                FLIT_out           = flits[owner_q];
                VALID_out          = VALID_in[owner_q];
                STALL_out[owner_q] = STALL_in;
                xfer               = VALID_in[owner_q] & ~STALL_in;
                if (xfer && !flits[owner_q][NOTTAIL_BIT]) begin
                    state_d = ARB_IDLE;
                    ptr_d   = owner_q;
                    grant_d = '0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign GRANT_out = grant_q;

`ifdef SWITCH_ARB_STATS_EN
    logic [15:0] pkt_cnt_q;
    logic [15:0] stall_cnt_q;
    logic        tail_xfer;
    logic        stall_cycle;

    assign tail_xfer   = xfer & ~FLIT_out[NOTTAIL_BIT];
    assign stall_cycle = VALID_out & STALL_in;

    // Free-running wrap-around activity counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (tail_xfer)   pkt_cnt_q   <= pkt_cnt_q + 16'd1;
            if (stall_cycle) stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign PKT_COUNT_out   = pkt_cnt_q;
    assign STALL_COUNT_out = stall_cnt_q;
`endif

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Bench for switch_output_arbiter: per-cycle reference model of the arbitration
// rules plus directed scenarios pinned with hand-computed expectations.
module tb_switch_output_arbiter;
    import switch_output_arbiter_pkg::*;

    localparam int unsigned NI = 4;
    localparam int unsigned FW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [NI*FW-1:0] flit_bus;
    logic [NI-1:0]    vin;
    logic [NI-1:0]    stall_out;
    logic [FW-1:0]    flit_out;
    logic             valid_out;
    logic             stall_in;
    logic [NI-1:0]    grant_out;
`ifdef SWITCH_ARB_STATS_EN
    logic [15:0]      pkt_count;
    logic [15:0]      stall_count;
`endif

    switch_output_arbiter #(
        .FLITWIDTH(32), .NUMBERINPUTS(4), .LOGNUMBERINPUTS(2),
        .LOGNUMBEROUTPUTS(2), .PORTID(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .FLIT_in   (flit_bus),
        .VALID_in  (vin),
        .STALL_out (stall_out),
        .FLIT_out  (flit_out),
        .VALID_out (valid_out),
        .STALL_in  (stall_in),
        .GRANT_out (grant_out)
`ifdef SWITCH_ARB_STATS_EN
        ,
        .PKT_COUNT_out   (pkt_count),
        .STALL_COUNT_out (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Per-input pending flits (input buffers) and what is presented this cycle
    logic [31:0] q [NI][$];
    logic [31:0] cur_f [NI];

    // Reference model state
    bit          m_valid = 1'b0;
    bit          m_locked;
    int          m_owner, m_ptr;
    logic [15:0] m_pkt, m_stall;
    int          wait_pk [NI];

    // Logs and scenario controls
    int          grant_log [$];
    logic [31:0] out_log [$];
    int          lock_cycles, stall_cycles, cyc, t_present, t_out;
    int          push_count, xfer_count;
    bit          rst_req, bubble_en, fair_en;
    int          stall_pct, stall_after, stall_left;

    logic [NI-1:0] eg, es;
    logic [31:0]   ef;
    logic          ev;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive on negedge, sample #1 later, then advance the model through the next posedge.
    always begin
        @(negedge clk);
        cyc++;
        rst = rst_req;
        for (int i = 0; i < NI; i++) begin
            if (q[i].size() > 0 && (!bubble_en || $urandom_range(99) >= 25)) begin
                vin[i]   = 1'b1;
                cur_f[i] = q[i][0];
            end else begin
                vin[i]   = 1'b0;
                cur_f[i] = $urandom;
            end
            flit_bus[i*FW +: FW] = cur_f[i];
        end
        if (rst_req) stall_in = 1'b1;
        else if (stall_after >= 0 && out_log.size() == stall_after && stall_left > 0) begin
            stall_in = 1'b1;
            stall_left--;
        end else stall_in = ($urandom_range(99) < 32'(stall_pct));
        #1;
        if (m_valid) begin
            es = '1;
            if (m_locked) begin
                eg = NI'(1) << m_owner;
                ef = cur_f[m_owner];
                ev = vin[m_owner];
                es[m_owner] = stall_in;
            end else begin
                eg = '0;
                ef = '0;
                ev = 1'b0;
            end
            chk("grant", 32'(grant_out), 32'(eg));
            chk("flit_out", flit_out, ef);
            chk("valid_out", 32'(valid_out), 32'(ev));
            chk("stall_out", 32'(stall_out), 32'(es));
`ifdef SWITCH_ARB_STATS_EN
            chk("pkt_count", 32'(pkt_count), 32'(m_pkt));
            chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
            if (grant_out != '0) lock_cycles++;
            if (valid_out && stall_in) stall_cycles++;
            if (vin != '0 && t_present < 0) t_present = cyc;
            if (valid_out && t_out < 0) t_out = cyc;
        end
        if (rst) begin
            m_valid  = 1'b1;
            m_locked = 1'b0;
            m_owner  = 0;
            m_ptr    = NI - 1;
            m_pkt    = '0;
            m_stall  = '0;
            for (int i = 0; i < NI; i++) begin
                q[i].delete();
                wait_pk[i] = 0;
            end
        end else if (m_valid) begin
            if (m_locked) begin
                if (vin[m_owner] && !stall_in) begin
                    out_log.push_back(cur_f[m_owner]);
                    xfer_count++;
                    void'(q[m_owner].pop_front());
                    if (!cur_f[m_owner][1]) begin
                        m_pkt++;
                        grant_log.push_back(m_owner);
                        m_ptr    = m_owner;
                        m_locked = 1'b0;
                        if (fair_en) begin
                            for (int i = 0; i < NI; i++) begin
                                if (i != m_owner && q[i].size() > 0 && q[i][0][0]) begin
                                    wait_pk[i]++;
                                    chk("fairness", 32'(wait_pk[i] <= NI - 1), 32'd1);
                                end
                            end
                        end
                    end
                end else if (vin[m_owner] && stall_in) m_stall++;
            end else begin
                for (int k = 1; k <= NI; k++) begin
                    int c;
                    c = (m_ptr + k) % NI;
                    if (!m_locked && vin[c] && cur_f[c][0] && cur_f[c][4:3] == 2'b00) begin
                        m_locked   = 1'b1;
                        m_owner    = c;
                        wait_pk[c] = 0;
                    end
                end
            end
        end
    end

    task automatic clear_logs();
        grant_log.delete();
        out_log.delete();
        lock_cycles = 0;
        stall_cycles = 0;
        t_present = -1;
        t_out = -1;
        push_count = 0;
        xfer_count = 0;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        repeat (2) @(posedge clk);
        rst_req = 1'b0;
        clear_logs();
    endtask

    task automatic push(input int i, input logic [31:0] f);
        q[i].push_back(f);
        push_count++;
    endtask

    task automatic gen_pkt(input int i, input int len);
        logic [31:0] w;
        w = $urandom;
        if (len == 1) push(i, {w[31:5], 2'b00, CTRL_SINGLE});
        else begin
            push(i, {w[31:5], 2'b00, CTRL_HEADER});
            for (int p = 0; p < len - 2; p++) begin
                w = $urandom;
                push(i, {w[31:3], CTRL_PAYLOAD});
            end
            w = $urandom;
            push(i, {w[31:3], CTRL_TAIL});
        end
    endtask

    task automatic wait_drain(input int budget);
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < budget) begin
            busy = m_locked;
            for (int i = 0; i < NI; i++) if (q[i].size() > 0) busy = 1'b1;
            if (busy) begin
                @(posedge clk);
                n++;
            end
        end
        chk("drain_timeout", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic check_grants(input string nm, input int exp[$]);
        chk({nm, "_count"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < grant_log.size(); i++)
            chk(nm, 32'(grant_log[i]), 32'(exp[i]));
    endtask

    task automatic check_flits(input string nm, input logic [31:0] exp[$]);
        chk({nm, "_count"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(nm, out_log[i], exp[i]);
    endtask

    initial begin
        int n;
        rst = 1'b1; rst_req = 1'b1; stall_in = 1'b1; vin = '0; flit_bus = '0;
        bubble_en = 1'b0; fair_en = 1'b0; stall_pct = 0; stall_after = -1; stall_left = 0;
        cyc = 0;
        clear_logs();
        do_reset();

        // Single 3-flit packet from input 2
        push(2, 32'h0000_0003); push(2, 32'h1234_5672); push(2, 32'h89AB_CDE8);
        wait_drain(100);
        check_grants("t1_grant", '{2});
        check_flits("t1_flits", '{32'h0000_0003, 32'h1234_5672, 32'h89AB_CDE8});
        chk("t1_lock_cycles", 32'(lock_cycles), 32'd3);
        chk("t1_latency", 32'(t_out - t_present), 32'd1);

        // Three simultaneous contenders, input 0 queues a second packet
        do_reset();
        fair_en = 1'b1;
        gen_pkt(0, 3); gen_pkt(1, 3); gen_pkt(3, 3); gen_pkt(0, 3);
        wait_drain(200);
        check_grants("t2_order", '{0, 1, 3, 0});
        chk("t2_lock_cycles", 32'(lock_cycles), 32'd12);

        // Downstream stall of 3 cycles after header and first payload
        do_reset();
        stall_after = 2; stall_left = 3;
        push(2, 32'h0000_0023); push(2, 32'h1111_1112); push(2, 32'h2222_2222); push(2, 32'h3333_3330);
        wait_drain(100);
        stall_after = -1;
        check_flits("t3_flits", '{32'h0000_0023, 32'h1111_1112, 32'h2222_2222, 32'h3333_3330});
        chk("t3_stall_cycles", 32'(stall_cycles), 32'd3);
        chk("t3_lock_cycles", 32'(lock_cycles), 32'd7);

        // Header for another output port is never granted
        do_reset();
        push(1, 32'h0000_0013);
        repeat (12) @(posedge clk);
        chk("t4_lock_cycles", 32'(lock_cycles), 32'd0);
        chk("t4_grants", 32'(grant_log.size()), 32'd0);
        chk("t4_held", 32'(q[1].size()), 32'd1);
        chk("t4_stall1", 32'(stall_out[1]), 32'd1);

        // Single-flit packet from input 3
        do_reset();
        push(3, 32'hCAFE_0001);
        wait_drain(100);
        chk("t5_lock_cycles", 32'(lock_cycles), 32'd1);
        check_grants("t5_grant", '{3});

        // Reset in the middle of a packet
        do_reset();
        gen_pkt(0, 4);
        n = 0;
        while (out_log.size() < 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        chk("t6_reach_mid", 32'(out_log.size() >= 2), 32'd1);
        do_reset();
        @(negedge clk);
        #2;
        chk("t6_grant_after_rst", 32'(grant_out), 32'd0);
`ifdef SWITCH_ARB_STATS_EN
        chk("t6_pkt_after_rst", 32'(pkt_count), 32'd0);
`endif
        push(2, 32'h0BAD_0001);
        wait_drain(100);
        check_grants("t6_grant", '{2});
`ifdef SWITCH_ARB_STATS_EN
        chk("t6_pkt_after_tail", 32'(pkt_count), 32'd1);
`endif

        // Randomised traffic: without bubbles (fairness checked), then with bubbles
        for (int ph = 0; ph < 2; ph++) begin
            do_reset();
            bubble_en = (ph == 1);
            fair_en   = (ph == 0);
            stall_pct = 25;
            for (int it = 0; it < 400; it++) begin
                int i;
                @(posedge clk);
                i = $urandom_range(NI - 1);
                if ($urandom_range(2) == 0 && q[i].size() < 10) gen_pkt(i, $urandom_range(1, 5));
            end
            wait_drain(4000);
            chk("rand_delivered", 32'(xfer_count), 32'(push_count));
            stall_pct = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
